wb_arb_mux: RTL and testbench
=============================

Name: wb_arb_mux

Overview:
- Parametrised successor to the single-master Wishbone IO mux: NUM_MASTERS masters to NUM_SLAVES slaves through one shared bus.
- Round-robin arbitration, with the grant held for the whole CYC.
- Mask/match address decode taken from parameter arrays.
- Unmapped accesses answered with a generated ERR.
- Sits between the core/debug/DMA masters and the SoC peripheral map.

Parameters:
- NUM_MASTERS, 2, number of masters (1..8).
- NUM_SLAVES, 12, number of slaves (1..16).
- MATCH_ADDR, {NUM_SLAVES{32'h0}}, packed 32-bit base per slave; slave 0 in bits [31:0].
- MATCH_MASK, {NUM_SLAVES{32'h0}}, packed 32-bit mask per slave.
- TIMEOUT_CYCLES, 255, bus-timeout limit; used only when the optional feature is compiled in.

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbm_adr_i  in  32*NUM_MASTERS  master addresses; master m in [32m+31:32m].
- wbm_dat_i  in  32*NUM_MASTERS  master write data.
- wbm_sel_i  in  4*NUM_MASTERS  byte selects.
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS  per-master controls.
- wbm_dat_o  out  32*NUM_MASTERS  read data.
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS  per-master terminations.
- wbs_adr_o, wbs_dat_o  out  32*NUM_SLAVES  slave address / write data.
- wbs_sel_o  out  4*NUM_SLAVES  slave byte selects.
- wbs_we_o, wbs_cyc_o, wbs_stb_o  out  NUM_SLAVES  slave controls.
- wbs_dat_i  in  32*NUM_SLAVES  slave read data.
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  NUM_SLAVES  slave terminations.
- grant_o  out  NUM_MASTERS  one-hot current grant (debug/perf).

Behaviour:
- **Reset.** All outputs 0, state IDLE, round-robin pointer = 0, error flag 0, timeout counter 0.
- **IDLE.**
  - Candidates are masters with cyc=1; the winner is the first candidate at or after the pointer, wrapping modulo NUM_MASTERS.
  - Grant is registered: a request seen in cycle t gives grant_o and slave cyc/stb in cycle t+1.
  - On grant: pointer <= winner+1 mod NUM_MASTERS; go to BUSY.
- **BUSY.**
  - The granted master's adr/dat/sel/we are broadcast to all slaves.
  - Only the decoded slave sees cyc/stb. Its cyc = master cyc; its stb = master stb (combinational).
  - Decode: slave s matches when (adr & MASK[s]) == (ADDR[s] & MASK[s]); lowest matching index wins.
  - Ack/err/rty/dat of the decoded slave route combinationally to the granted master. All other masters get 0s on every output.
  - When the granted master drops cyc: go to IDLE and clear grant_o the next cycle. This always leaves at least one idle cycle between grants.
- **Unmapped address** (stb=1, no match):
  - No slave cyc/stb is asserted.
  - The error flag is registered, giving wbm_err_o=1 to the granted master for exactly one cycle, one cycle after stb.
  - The flag self-clears the following cycle even if stb stays high; a fresh unmapped stb then repeats the pattern (err every 2nd cycle).
- **Simultaneous events:**
  - Requests from other masters during BUSY are ignored.
  - A master dropping cyc in the same cycle it was granted still returns the arbiter to IDLE.
  - A slave asserting both ack and err is passed through unchanged.
- **Mid-operation reset.** Asserting wb_rst_ni in any state forces IDLE and all-zero outputs immediately (asynchronous). Deassertion is synchronised by the SoC reset block.
- **Width rules.** The pointer is $clog2(NUM_MASTERS) bits, minimum 1; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

Optional Feature:
- Macro: WB_ARB_MUX_TIMEOUT_EN.
- **Defined:**
  - The counter increments each BUSY cycle with stb=1 and no ack/err/rty from the decoded slave, and clears on any termination or when stb drops.
  - When the counter reaches TIMEOUT_CYCLES, wbm_err_o pulses for one cycle to the granted master and the slave stb is forced to 0 in that same cycle.
  - The counter then clears.
- **Undefined:** no counter is built and a hung slave stalls the bus indefinitely.

Test Plan:
- **Single read.** M0 reads 0x20000104 (GPIO at index 7, mask ffffff00); slave returns ack with 0xDEADBEEF. Required: slave 7 stb goes high one cycle after M0 cyc; M0 gets dat 0xDEADBEEF with ack; grant_o=01.
- **Round-robin.** M0 and M1 assert cyc in the same cycle, both repeating 3 transactions each. Required: grant order M0, M1, M0, M1, M0, M1, with one idle cycle between grants.
- **Unmapped address.** M1 issues stb to 0x40000000. Required: no wbs_stb_o bit set; M1 err=1 exactly one cycle later; M0 outputs stay 0.
- **Reset mid-transaction.** With slave stb=1, drive wb_rst_ni=0. Required: all wbs_cyc_o/stb_o, grant_o and master ack/err go 0 in the same cycle; the next grant goes to M0.
- **Timeout (WB_ARB_MUX_TIMEOUT_EN, TIMEOUT_CYCLES=8).** Slave never acks. Required: M0 err pulses on the 8th stalled cycle and slave stb=0 in that cycle; without the macro, no err after 100 cycles.
- **Priority decode.** Two overlapping windows (slaves 2 and 5 both match 0x80000010). Required: only slave 2 sees stb.

Source files
------------

// File: rtl/wb_arb_mux.sv
// Round-robin NUM_MASTERS-to-NUM_SLAVES Wishbone interconnect with mask/match address decode.
// Define WB_ARB_MUX_TIMEOUT_EN to build the optional stalled-slave bus timeout.
module wb_arb_mux #(
    parameter int unsigned               NUM_MASTERS    = 2,
    parameter int unsigned               NUM_SLAVES     = 12,
    parameter logic [32*NUM_SLAVES-1:0] MATCH_ADDR     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] MATCH_MASK     = {NUM_SLAVES{32'h0}},
    parameter int unsigned               TIMEOUT_CYCLES = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
    input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
    input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [32*NUM_SLAVES-1:0]  wbs_adr_o,
    output logic [32*NUM_SLAVES-1:0]  wbs_dat_o,
    output logic [4*NUM_SLAVES-1:0]   wbs_sel_o,
    output logic [NUM_SLAVES-1:0]     wbs_we_o,
    output logic [NUM_SLAVES-1:0]     wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]     wbs_stb_o,
    input  logic [32*NUM_SLAVES-1:0]  wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]     wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]     wbs_err_i,
    input  logic [NUM_SLAVES-1:0]     wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);
    localparam int unsigned PtrW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SelW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic                   err_q, err_d;

    logic [31:0]     m_adr, m_dat;
    logic [3:0]      m_sel;
    logic            m_we, m_cyc, m_stb;
    logic            hit;
    logic [SelW-1:0] sidx;
    logic            s_ack, s_err, s_rty;
    logic [31:0]     s_dat;
    logic            found;
    logic [PtrW-1:0] win;
    logic            tmo_fire;

    // Granted master's request; all zero while no grant is held.
    always_comb begin
        m_adr = '0;
        m_dat = '0;
        m_sel = '0;
        m_we  = 1'b0;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            if (grant_q[m]) begin
                m_adr = m_adr | wbm_adr_i[32*m +: 32];
                m_dat = m_dat | wbm_dat_i[32*m +: 32];
                m_sel = m_sel | wbm_sel_i[4*m +: 4];
                m_we  = m_we  | wbm_we_i[m];
                m_cyc = m_cyc | wbm_cyc_i[m];
                m_stb = m_stb | wbm_stb_i[m];
            end
        end
    end

    // Scan downwards so the lowest matching window wins.
    always_comb begin
        hit  = 1'b0;
        sidx = '0;
        for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
            if ((m_adr & MATCH_MASK[32*s +: 32]) ==
                (MATCH_ADDR[32*s +: 32] & MATCH_MASK[32*s +: 32])) begin
                hit  = 1'b1;
                sidx = SelW'(s);
            end
        end
    end

    assign s_ack = hit & wbs_ack_i[sidx];
    assign s_err = hit & wbs_err_i[sidx];
    assign s_rty = hit & wbs_rty_i[sidx];
    assign s_dat = hit ? wbs_dat_i[32*int'(sidx) +: 32] : 32'h0;

    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            idx = (32'(ptr_q) + k) % NUM_MASTERS;
            if (!found && wbm_cyc_i[idx]) begin
                found = 1'b1;
                win   = PtrW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    ptr_d        = PtrW'((32'(win) + 32'd1) % NUM_MASTERS);
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (!m_cyc) begin
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Unmapped strobe: one-cycle error, then one quiet cycle before it can repeat.
    assign err_d = (state_q == StBusy) && m_cyc && m_stb && !hit && !err_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

`ifdef WB_ARB_MUX_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            stalled;

    assign stalled  = (state_q == StBusy) && m_cyc && m_stb && hit && !(s_ack || s_err || s_rty);
    assign tmo_fire = stalled && ((32'(tmo_q) + 32'd1) >= TIMEOUT_CYCLES);
    assign tmo_d    = (stalled && !tmo_fire) ? tmo_q + 1'b1 : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign tmo_fire           = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = '0;
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        wbm_dat_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            wbs_adr_o[32*s +: 32] = m_adr;
            wbs_dat_o[32*s +: 32] = m_dat;
            wbs_sel_o[4*s +: 4]   = m_sel;
            wbs_we_o[s]           = m_we;
        end
        if (hit) begin
            wbs_cyc_o[sidx] = m_cyc;
            wbs_stb_o[sidx] = m_stb & ~tmo_fire;
        end
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            if (grant_q[m]) begin
                wbm_dat_o[32*m +: 32] = s_dat;
                wbm_ack_o[m]          = s_ack;
                wbm_err_o[m]          = s_err | err_q | tmo_fire;
                wbm_rty_o[m]          = s_rty;
            end
        end
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_arb_mux.sv
// Self-checking bench for wb_arb_mux: two masters, twelve slaves, randomized traffic
// checked against a decode/round-robin reference model.
module tb_wb_arb_mux;
    localparam int NM  = 2;
    localparam int NS  = 12;
    localparam int TMO = 8;

    function automatic logic [31:0] ref_base(input int s);
        case (s)
            2:       return 32'h8000_0000;
            5:       return 32'h8000_0010;
            7:       return 32'h2000_0100;
            default: return 32'h1000_0000 | (32'(s) << 16);
        endcase
    endfunction

    function automatic logic [31:0] ref_mask(input int s);
        case (s)
            2, 7:    return 32'hffff_ff00;
            5:       return 32'hffff_fff0;
            default: return 32'hffff_0000;
        endcase
    endfunction

    function automatic logic [32*NS-1:0] pack_base();
        logic [32*NS-1:0] v;
        v = '0;
        for (int s = 0; s < NS; s++) v[32*s +: 32] = ref_base(s);
        return v;
    endfunction

    function automatic logic [32*NS-1:0] pack_mask();
        logic [32*NS-1:0] v;
        v = '0;
        for (int s = 0; s < NS; s++) v[32*s +: 32] = ref_mask(s);
        return v;
    endfunction

    // First window (lowest index) containing the address, or -1.
    function automatic int ref_decode(input logic [31:0] a);
        for (int s = 0; s < NS; s++) begin
            if ((a & ref_mask(s)) == (ref_base(s) & ref_mask(s))) return s;
        end
        return -1;
    endfunction

    localparam logic [32*NS-1:0] TB_ADDR = pack_base();
    localparam logic [32*NS-1:0] TB_MASK = pack_mask();

    logic             clk;
    logic             rst_n;
    logic [32*NM-1:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic [4*NM-1:0]  wbm_sel_i;
    logic [NM-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [32*NS-1:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [4*NS-1:0]  wbs_sel_o;
    logic [NS-1:0]    wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic [NM-1:0]    grant_o;

    logic [31:0] slv_rdata [NS];
    logic        slv_ack_en;
    logic        slv_err_en;

    int checks    = 0;
    int passes    = 0;
    int model_ptr = 0;

    wb_arb_mux #(
        .NUM_MASTERS   (NM),
        .NUM_SLAVES    (NS),
        .MATCH_ADDR    (TB_ADDR),
        .MATCH_MASK    (TB_MASK),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbm_adr_i(wbm_adr_i),
        .wbm_dat_i(wbm_dat_i),
        .wbm_sel_i(wbm_sel_i),
        .wbm_we_i (wbm_we_i),
        .wbm_cyc_i(wbm_cyc_i),
        .wbm_stb_i(wbm_stb_i),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o),
        .wbs_dat_o(wbs_dat_o),
        .wbs_sel_o(wbs_sel_o),
        .wbs_we_o (wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i),
        .grant_o  (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait slaves: terminate in the same cycle their strobe is seen.
    always_comb begin
        wbs_dat_i = '0;
        wbs_ack_i = slv_ack_en ? wbs_stb_o : '0;
        wbs_err_i = slv_err_en ? wbs_stb_o : '0;
        wbs_rty_i = '0;
        for (int s = 0; s < NS; s++) wbs_dat_i[32*s +: 32] = slv_rdata[s];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic on, input logic [31:0] adr,
                           input logic we, input logic [31:0] dat);
        wbm_cyc_i[m]          = on;
        wbm_stb_i[m]          = on;
        wbm_adr_i[32*m +: 32] = adr;
        wbm_we_i[m]           = we;
        wbm_dat_i[32*m +: 32] = dat;
        wbm_sel_i[4*m +: 4]   = 4'hf;
    endtask

    task automatic end_xfer();
        tick();
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        wbm_adr_i  = '0;
        wbm_dat_i  = '0;
        wbm_sel_i  = '0;
        wbm_we_i   = '0;
        wbm_cyc_i  = '0;
        wbm_stb_i  = '0;
        slv_ack_en = 1'b1;
        slv_err_en = 1'b0;
        for (int s = 0; s < NS; s++) slv_rdata[s] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant_o !== '0) $display("FAIL rst_grant: got %b want 0", grant_o);
        else passes++;
        checks++;
        if ({wbs_cyc_o, wbs_stb_o} !== '0) $display("FAIL rst_slv_ctl: got %h want 0", {wbs_cyc_o, wbs_stb_o});
        else passes++;
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== '0)
            $display("FAIL rst_term: got %b want 0", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        else passes++;
        checks++;
        if ({wbs_adr_o, wbm_dat_o, wbs_we_o} !== '0) $display("FAIL rst_data: got nonzero want 0");
        else passes++;
        rst_n     = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_single_read();
        slv_rdata[7] = 32'hDEAD_BEEF;
        tick();
        drive_m(0, 1'b1, 32'h2000_0104, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if ({grant_o, wbs_stb_o} !== '0) $display("FAIL rd_latency: got %b/%h want 0/0", grant_o, wbs_stb_o);
        else passes++;
        @(negedge clk);
        model_ptr = 1;
        checks++;
        if (grant_o !== 2'b01) $display("FAIL rd_grant: got %b want 01", grant_o);
        else passes++;
        checks++;
        if (wbs_stb_o !== 12'h080) $display("FAIL rd_stb: got %h want 080", wbs_stb_o);
        else passes++;
        checks++;
        if ({wbm_ack_o, wbm_dat_o} !== {2'b01, 32'h0, 32'hDEAD_BEEF})
            $display("FAIL rd_data: got %b %h want 01 00000000deadbeef", wbm_ack_o, wbm_dat_o);
        else passes++;
        end_xfer();
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00) $display("FAIL rd_release: got %b want 00", grant_o);
        else passes++;
    endtask

    task automatic test_priority();
        slv_err_en = 1'b1;
        tick();
        drive_m(0, 1'b1, 32'h8000_0010, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        model_ptr = 1;
        checks++;
        if (wbs_stb_o !== 12'h004) $display("FAIL prio_stb: got %h want 004", wbs_stb_o);
        else passes++;
        checks++;
        if ({wbm_ack_o, wbm_err_o} !== 4'b0101)
            $display("FAIL prio_ack_err: got %b want 0101", {wbm_ack_o, wbm_err_o});
        else passes++;
        slv_err_en = 1'b0;
        end_xfer();
    endtask

    task automatic test_unmapped();
        logic [NM-1:0] exp_err;
        tick();
        drive_m(1, 1'b1, 32'h4000_0000, 1'b1, 32'h1234_5678);
        repeat (2) @(negedge clk);
        model_ptr = 0;
        checks++;
        if ({grant_o, wbs_cyc_o, wbs_stb_o, wbm_err_o} !== {2'b10, 26'h0})
            $display("FAIL unm_first: got %b %h %h %b want 10 0 0 00", grant_o, wbs_cyc_o, wbs_stb_o, wbm_err_o);
        else passes++;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            exp_err = {(k % 2 == 0), 1'b0};
            checks++;
            if (wbm_err_o !== exp_err) $display("FAIL unm_err_c%0d: got %b want %b", k, wbm_err_o, exp_err);
            else passes++;
        end
        checks++;
        if ({wbm_ack_o[0], wbm_dat_o[31:0], wbs_stb_o} !== '0) $display("FAIL unm_m0_quiet: got nonzero want 0");
        else passes++;
        end_xfer();
    endtask

    task automatic test_round_robin();
        int            rem [NM];
        logic          pause [NM];
        logic [NM-1:0] req, req_prev, g, prev_g;
        logic [31:0]   adr [NM];
        int            ngr, exp_m;
        logic [NS-1:0] exp_stb;
        adr[0]   = ref_base(3) | 32'h4;
        adr[1]   = ref_base(9) | 32'h8;
        ngr      = 0;
        req_prev = '0;
        prev_g   = '0;
        for (int m = 0; m < NM; m++) begin
            rem[m]   = 3;
            pause[m] = 1'b0;
        end
        for (int c = 0; c < 200; c++) begin
            tick();
            for (int m = 0; m < NM; m++) begin
                req[m] = (rem[m] > 0) && !pause[m];
                pause[m] = 1'b0;
                drive_m(m, req[m], adr[m], 1'b0, 32'h0);
            end
            @(negedge clk);
            g = grant_o;
            if (g !== prev_g && g !== '0) begin
                checks++;
                if (prev_g !== '0) $display("FAIL rr_gap: got %b after %b want idle between", g, prev_g);
                else passes++;
                exp_m = -1;
                for (int k = 0; k < NM; k++) begin
                    if (exp_m < 0 && req_prev[(model_ptr + k) % NM]) exp_m = (model_ptr + k) % NM;
                end
                checks++;
                if (exp_m < 0 || g !== NM'(1 << exp_m)) $display("FAIL rr_order%0d: got %b want m%0d", ngr, g, exp_m);
                else passes++;
                exp_stb = (exp_m == 0) ? NS'(1 << 3) : NS'(1 << 9);
                checks++;
                if (wbs_stb_o !== exp_stb) $display("FAIL rr_stb%0d: got %h want %h", ngr, wbs_stb_o, exp_stb);
                else passes++;
                if (exp_m >= 0) model_ptr = (exp_m + 1) % NM;
                ngr++;
            end
            for (int m = 0; m < NM; m++) begin
                if (g[m] && wbm_ack_o[m]) begin
                    rem[m]--;
                    pause[m] = 1'b1;
                end
            end
            prev_g   = g;
            req_prev = req;
            if (rem[0] == 0 && rem[1] == 0 && g === '0) break;
        end
        checks++;
        if (ngr != 6 || rem[0] != 0 || rem[1] != 0)
            $display("FAIL rr_count: got %0d grants rem %0d/%0d want 6 0/0", ngr, rem[0], rem[1]);
        else passes++;
        end_xfer();
    endtask

    task automatic test_reset_mid();
        slv_ack_en = 1'b0;
        tick();
        drive_m(0, 1'b1, 32'h2000_0104, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        model_ptr = 1;
        checks++;
        if (wbs_stb_o !== 12'h080) $display("FAIL mid_pre_stb: got %h want 080", wbs_stb_o);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        model_ptr = 0;
        checks++;
        if ({wbs_cyc_o, wbs_stb_o, grant_o} !== '0)
            $display("FAIL mid_rst_ctl: got %h %h %b want 0", wbs_cyc_o, wbs_stb_o, grant_o);
        else passes++;
        checks++;
        if ({wbm_ack_o, wbm_err_o} !== '0) $display("FAIL mid_rst_term: got %b want 0", {wbm_ack_o, wbm_err_o});
        else passes++;
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive_m(0, 1'b1, ref_base(4), 1'b0, 32'h0);
        drive_m(1, 1'b1, ref_base(6), 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (grant_o !== NM'(1 << model_ptr)) $display("FAIL mid_next_grant: got %b want m%0d", grant_o, model_ptr);
        else passes++;
        model_ptr = (model_ptr + 1) % NM;
        slv_ack_en = 1'b1;
        end_xfer();
    endtask

    task automatic test_timeout();
        int            ncyc;
        logic [NM-1:0] exp_err;
        logic [NS-1:0] exp_stb;
`ifdef WB_ARB_MUX_TIMEOUT_EN
        ncyc = 3 * TMO;
`else
        ncyc = 100;
`endif
        slv_ack_en = 1'b0;
        tick();
        drive_m(0, 1'b1, 32'h2000_0104, 1'b0, 32'h0);
        @(negedge clk);
        model_ptr = 1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
`ifdef WB_ARB_MUX_TIMEOUT_EN
            exp_err = (k % TMO == 0) ? 2'b01 : 2'b00;
`else
            exp_err = 2'b00;
`endif
            exp_stb = (exp_err != 0) ? '0 : NS'(1 << 7);
            checks++;
            if ({wbm_err_o, wbs_stb_o} !== {exp_err, exp_stb})
                $display("FAIL tmo_c%0d: got %b/%h want %b/%h", k, wbm_err_o, wbs_stb_o, exp_err, exp_stb);
            else passes++;
        end
        slv_ack_en = 1'b1;
        end_xfer();
    endtask

    task automatic test_random();
        int            m, idx;
        logic [31:0]   adr, wd;
        logic          we;
        logic [NS-1:0] exp_stb;
        for (int it = 0; it < 24; it++) begin
            m  = $urandom_range(0, NM - 1);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            for (int s = 0; s < NS; s++) slv_rdata[s] = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                adr = 32'h4000_0000 | ($urandom & 32'h00ff_fffc);
            end else begin
                idx = $urandom_range(0, NS - 1);
                adr = ref_base(idx) | ($urandom & ~ref_mask(idx));
            end
            idx     = ref_decode(adr);
            exp_stb = (idx >= 0) ? NS'(1 << idx) : '0;
            tick();
            drive_m(m, 1'b1, adr, we, wd);
            repeat (2) @(negedge clk);
            model_ptr = (m + 1) % NM;
            checks++;
            if ({grant_o, wbs_stb_o} !== {NM'(1 << m), exp_stb})
                $display("FAIL rnd%0d_route: got %b/%h want %b/%h", it, grant_o, wbs_stb_o, NM'(1 << m), exp_stb);
            else passes++;
            if (idx >= 0) begin
                checks++;
                if (wbs_adr_o[32*idx +: 32] !== adr || wbs_we_o[idx] !== we ||
                    (we && wbs_dat_o[32*idx +: 32] !== wd))
                    $display("FAIL rnd%0d_req: got %h/%b/%h want %h/%b/%h", it, wbs_adr_o[32*idx +: 32],
                             wbs_we_o[idx], wbs_dat_o[32*idx +: 32], adr, we, wd);
                else passes++;
                checks++;
                if (wbm_ack_o !== NM'(1 << m) || wbm_dat_o[32*m +: 32] !== slv_rdata[idx] ||
                    wbm_dat_o[32*(1-m) +: 32] !== 32'h0)
                    $display("FAIL rnd%0d_resp: got %b %h want %b %h", it, wbm_ack_o, wbm_dat_o,
                             NM'(1 << m), slv_rdata[idx]);
                else passes++;
            end else begin
                @(negedge clk);
                checks++;
                if (wbm_err_o !== NM'(1 << m)) $display("FAIL rnd%0d_err: got %b want %b", it, wbm_err_o, NM'(1 << m));
                else passes++;
            end
            end_xfer();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_unmapped();
        test_round_robin();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion (%0d/%0d)", passes, checks);
        $fatal(1);
    end

endmodule
